cp0_excpt_sched: RTL and testbench

- Exception/interrupt scheduler for the single-cycle CPU; the sequencing partner of the exception-control module (Ctrl).
- Holds the CP0 state: Count, Compare, Status, Cause, EPC. Runs the timer.
- Arbitrates timer interrupt, syscall and eret, then drives excptype and epc to Ctrl, which turns them into the redirect (ejpc).

---
 rtl/cp0_excpt_sched_if.sv | 25 ++
 rtl/cp0_excpt_sched.sv | 170 +++++++++++++++++
 tb/tb_cp0_excpt_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_excpt_sched_if.sv
// Bus between the CPU datapath and the CP0 exception scheduler:
// mtc0/mfc0 access, exception triggers and the redirect info handed to Ctrl.
interface cp0_excpt_sched_if;
  logic [31:0] pc;
  logic        is_syscall;
  logic        is_eret;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] excptype;
  logic [31:0] epc;
  logic        timer_irq;

  modport master (
    output pc, is_syscall, is_eret, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, excptype, epc, timer_irq
  );

  modport slave (
    input  pc, is_syscall, is_eret, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, excptype, epc, timer_irq
  );
endinterface

// File: rtl/cp0_excpt_sched.sv
// CP0 state (Count/Compare/Status/Cause/EPC), timer, and arbitration of
// timer interrupt, syscall and eret into excptype/epc for Ctrl.
module cp0_excpt_sched #(
  parameter int unsigned PRESCALE     = 1,
  parameter bit          TIMER_EN_RST = 1'b0
) (
  input logic               clk,
  input logic               rst,
  cp0_excpt_sched_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [AW-1:0] A_COUNT   = 5'd9;
  localparam logic [AW-1:0] A_COMPARE = 5'd11;
  localparam logic [AW-1:0] A_STATUS  = 5'd12;
  localparam logic [AW-1:0] A_CAUSE   = 5'd13;
  localparam logic [AW-1:0] A_EPC     = 5'd14;

  localparam logic [4:0]    EXC_INT = 5'd0;
  localparam logic [4:0]    EXC_SYS = 5'd8;

  localparam logic [DW-1:0] ET_TMR  = 32'h0000_0004;
  localparam logic [DW-1:0] ET_SYS  = 32'h0000_0100;
  localparam logic [DW-1:0] ET_ERET = 32'h0000_0200;

  typedef enum logic {ST_NORMAL = 1'b0, ST_HANDLER = 1'b1} state_t;
  typedef enum logic [1:0] {EV_NONE, EV_SYS, EV_TMR, EV_ERET} event_t;

  state_t        state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] compare_q, compare_d;
  logic [DW-1:0] epc_q, epc_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    exccode_q, exccode_d;
  logic          ie_q, ie_d;
  logic          te_q, te_d;
  logic          ip7_q, ip7_d;

  event_t        ev;
  logic          match;
  logic          wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // State register; EXL is the FSM state itself
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_NORMAL;
      count_q   <= '0;
      compare_q <= '0;
      epc_q     <= '0;
      presc_q   <= '0;
      exccode_q <= '0;
      ie_q      <= 1'b0;
      te_q      <= TIMER_EN_RST;
      ip7_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      presc_q   <= presc_d;
      exccode_q <= exccode_d;
      ie_q      <= ie_d;
      te_q      <= te_d;
      ip7_q     <= ip7_d;
    end
  end

  // Arbitration, timer and mtc0 next-state
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    compare_d    = compare_q;
    epc_d        = epc_q;
    presc_d      = presc_q;
    exccode_d    = exccode_q;
    ie_d         = ie_q;
    te_d         = te_q;
    ip7_d        = ip7_q;
    ev           = EV_NONE;
    bus.excptype = '0;

    wr_count   = bus.cp0_we && (bus.cp0_waddr == A_COUNT);
    wr_compare = bus.cp0_we && (bus.cp0_waddr == A_COMPARE);
    wr_status  = bus.cp0_we && (bus.cp0_waddr == A_STATUS);
    wr_cause   = bus.cp0_we && (bus.cp0_waddr == A_CAUSE);
    wr_epc     = bus.cp0_we && (bus.cp0_waddr == A_EPC);
    match      = te_q && (compare_q != '0) && (count_q == compare_q);

    // Nothing is taken while reset is asserted
    if (!rst) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (bus.is_syscall)  ev = EV_SYS;
          else if (ip7_q && ie_q) ev = EV_TMR;
        end
        ST_HANDLER: begin
          if (bus.is_eret) ev = EV_ERET;
        end
        default: ev = EV_NONE;
      endcase
    end

    if (te_q) begin
      if (presc_q == PW'(PRESCALE - 1)) begin
        presc_d = '0;
        count_d = count_q + 32'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (wr_count) begin
      count_d = bus.cp0_wdata;
      presc_d = '0;
    end
    if (wr_compare) compare_d = bus.cp0_wdata;

    // Compare write and software clear both beat a same-edge set
    ip7_d = ip7_q | match;
    if (wr_cause && !bus.cp0_wdata[15]) ip7_d = 1'b0;
    if (wr_compare)                     ip7_d = 1'b0;

    if (wr_status) begin
      ie_d    = bus.cp0_wdata[0];
      state_d = state_t'(bus.cp0_wdata[1]);
      te_d    = bus.cp0_wdata[2];
    end
    if (wr_epc) epc_d = bus.cp0_wdata;

    // Exception side effects override software writes to the same fields
    unique case (ev)
      EV_SYS: begin
        bus.excptype = ET_SYS;
        epc_d        = bus.pc + 32'd4;
        exccode_d    = EXC_SYS;
        state_d      = ST_HANDLER;
      end
      EV_TMR: begin
        bus.excptype = ET_TMR;
        epc_d        = bus.pc;
        exccode_d    = EXC_INT;
        state_d      = ST_HANDLER;
      end
      EV_ERET: begin
        bus.excptype = ET_ERET;
        state_d      = ST_NORMAL;
      end
      default: bus.excptype = '0;
    endcase
  end

  // mfc0 read mux
  always_comb begin
    bus.cp0_rdata = '0;
    unique case (bus.cp0_raddr)
      A_COUNT:   bus.cp0_rdata = count_q;
      A_COMPARE: bus.cp0_rdata = compare_q;
      A_STATUS:  bus.cp0_rdata = {29'd0, te_q, state_q == ST_HANDLER, ie_q};
      A_CAUSE:   bus.cp0_rdata = {16'd0, ip7_q, 8'd0, exccode_q, 2'd0};
      A_EPC:     bus.cp0_rdata = epc_q;
      default:   bus.cp0_rdata = '0;
    endcase
  end

  assign bus.epc       = epc_q;
  assign bus.timer_irq = ip7_q;

endmodule

// File: tb/tb_cp0_excpt_sched.sv
// Directed bench for cp0_excpt_sched: reset, timer, syscall, eret,
// simultaneous events, prescale/wrap on a second instance.
`timescale 1ns/1ps
module tb_cp0_excpt_sched;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  cp0_excpt_sched_if ia ();
  cp0_excpt_sched_if ib ();

  cp0_excpt_sched #(.PRESCALE(1), .TIMER_EN_RST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );
  cp0_excpt_sched #(.PRESCALE(4), .TIMER_EN_RST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and return all strobes to idle
  task automatic tick();
    @(posedge clk);
    #1;
    ia.cp0_we = 1'b0; ia.is_syscall = 1'b0; ia.is_eret = 1'b0;
    ib.cp0_we = 1'b0; ib.is_syscall = 1'b0; ib.is_eret = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    ia.cp0_we = 1'b1; ia.cp0_waddr = a; ia.cp0_wdata = d;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
    ib.cp0_we = 1'b1; ib.cp0_waddr = a; ib.cp0_wdata = d;
  endtask

  task automatic rd_a(input string tag, input logic [4:0] a, input logic [31:0] exp);
    ia.cp0_raddr = a; #1;
    chk(tag, ia.cp0_rdata, exp);
  endtask

  task automatic rd_b(input string tag, input logic [4:0] a, input logic [31:0] exp);
    ib.cp0_raddr = a; #1;
    chk(tag, ib.cp0_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ia.pc = '0; ia.is_syscall = 1'b1; ia.is_eret = 1'b0; ia.cp0_we = 1'b0;
    ia.cp0_waddr = '0; ia.cp0_wdata = '0; ia.cp0_raddr = '0;
    ib.pc = '0; ib.is_syscall = 1'b1; ib.is_eret = 1'b0; ib.cp0_we = 1'b0;
    ib.cp0_waddr = '0; ib.cp0_wdata = '0; ib.cp0_raddr = '0;

    // Reset held two cycles with syscall asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_excptype", ia.excptype, 32'h0);
    chk("rst_epc", ia.epc, 32'h0);
    chk("rst_irq", 32'(ia.timer_irq), 32'h0);
    rd_a("rst_status", 5'd12, 32'h0);
    rd_a("rst_count", 5'd9, 32'h0);
    rd_a("rst_compare", 5'd11, 32'h0);
    rd_a("rst_cause", 5'd13, 32'h0);
    rd_a("rst_epcreg", 5'd14, 32'h0);
    rd_b("rst_status_te", 5'd12, 32'h4);
    tick();
    rst = 1'b0;

    // Timer interrupt with PRESCALE=1
    ia.pc = 32'h100;
    tick(); wr_a(5'd11, 32'd10);
    tick(); wr_a(5'd12, 32'h5);
    tick(); ia.cp0_raddr = 5'd9; #1;
    n = 0;
    while (ia.cp0_rdata != 32'd10 && n < 40) begin
      tick(); ia.cp0_raddr = 5'd9; #1;
      n++;
    end
    chk("timer_match_cycle", 32'(n), 32'd10);
    chk("match_cycle_irq", 32'(ia.timer_irq), 32'h0);
    chk("match_cycle_exc", ia.excptype, 32'h0);
    tick(); ia.pc = 32'h124; #1;
    chk("timer_irq_rise", 32'(ia.timer_irq), 32'h1);
    chk("timer_exc", ia.excptype, 32'h4);
    tick(); #1;
    chk("timer_epc", ia.epc, 32'h124);
    chk("handler_exc_masked", ia.excptype, 32'h0);
    rd_a("timer_status", 5'd12, 32'h7);
    rd_a("timer_cause", 5'd13, 32'h8000);

    // Software clears IP7, then eret
    wr_a(5'd13, 32'h0);
    tick(); #1;
    chk("cause_clear_irq", 32'(ia.timer_irq), 32'h0);
    ia.is_eret = 1'b1; #1;
    chk("eret_exc", ia.excptype, 32'h200);
    chk("eret_epc", ia.epc, 32'h124);
    tick(); #1;
    rd_a("eret_status", 5'd12, 32'h5);
    ia.is_eret = 1'b1; #1;
    chk("eret_normal_exc", ia.excptype, 32'h0);
    tick(); #1;
    rd_a("eret_normal_status", 5'd12, 32'h5);

    // Syscall, masked second syscall, eret
    ia.pc = 32'h200; ia.is_syscall = 1'b1; #1;
    chk("sys_exc", ia.excptype, 32'h100);
    tick(); ia.pc = 32'h208; #1;
    chk("sys_epc", ia.epc, 32'h204);
    rd_a("sys_cause", 5'd13, 32'h20);
    rd_a("sys_status", 5'd12, 32'h7);
    ia.is_syscall = 1'b1; #1;
    chk("sys_in_handler_exc", ia.excptype, 32'h0);
    tick(); #1;
    chk("sys_in_handler_epc", ia.epc, 32'h204);
    ia.is_eret = 1'b1; #1;
    chk("sys_eret_exc", ia.excptype, 32'h200);
    chk("sys_eret_epc", ia.epc, 32'h204);
    tick(); #1;
    rd_a("sys_eret_status", 5'd12, 32'h5);

    // Syscall beats a pending timer; timer taken after eret
    wr_a(5'd11, 32'h30);
    tick(); wr_a(5'd9, 32'h2E);
    tick(); #1; rd_a("sim_count0", 5'd9, 32'h2E);
    tick();
    tick(); #1; rd_a("sim_match", 5'd9, 32'h30);
    tick(); ia.pc = 32'h300; ia.is_syscall = 1'b1; #1;
    chk("sim_irq", 32'(ia.timer_irq), 32'h1);
    chk("sim_sys_wins", ia.excptype, 32'h100);
    tick(); #1;
    chk("sim_epc", ia.epc, 32'h304);
    chk("sim_irq_pending", 32'(ia.timer_irq), 32'h1);
    chk("sim_handler_masked", ia.excptype, 32'h0);
    ia.is_eret = 1'b1; #1;
    chk("sim_eret_exc", ia.excptype, 32'h200);
    tick(); ia.pc = 32'h400; #1;
    chk("sim_timer_after_eret", ia.excptype, 32'h4);
    tick(); #1;
    chk("sim_timer_epc", ia.epc, 32'h400);
    rd_a("sim_timer_cause", 5'd13, 32'h8000);
    wr_a(5'd13, 32'h0); ia.is_eret = 1'b1; #1;
    chk("sim_clear_eret_exc", ia.excptype, 32'h200);
    tick(); #1;
    rd_a("sim_clear_status", 5'd12, 32'h5);
    chk("sim_clear_irq", 32'(ia.timer_irq), 32'h0);
    chk("sim_clear_exc", ia.excptype, 32'h0);

    // Compare write in the match cycle suppresses IP7
    wr_a(5'd11, 32'h51);
    tick(); wr_a(5'd9, 32'h50);
    tick(); #1; rd_a("cmp_count0", 5'd9, 32'h50);
    tick(); #1; rd_a("cmp_match", 5'd9, 32'h51);
    wr_a(5'd11, 32'h51);
    tick(); #1;
    chk("cmp_clear_wins", 32'(ia.timer_irq), 32'h0);
    chk("cmp_clear_exc", ia.excptype, 32'h0);

    // Unmapped registers and write-1 to IP7
    wr_a(5'd5, 32'hDEAD_BEEF);
    tick(); #1;
    rd_a("unmapped_rd5", 5'd5, 32'h0);
    rd_a("unmapped_rd10", 5'd10, 32'h0);
    wr_a(5'd13, 32'h8000);
    tick(); #1;
    chk("ip7_sw_set_ignored", 32'(ia.timer_irq), 32'h0);
    rd_a("ip7_sw_set_cause", 5'd13, 32'h0);

    // PRESCALE=4 wrap and TE=0 freeze on the second instance
    wr_b(5'd9, 32'hFFFF_FFFF);
    tick(); #1; rd_b("wrap_load", 5'd9, 32'hFFFF_FFFF);
    tick(); tick(); tick(); #1;
    rd_b("wrap_hold3", 5'd9, 32'hFFFF_FFFF);
    tick(); #1;
    rd_b("wrap_zero", 5'd9, 32'h0);
    wr_b(5'd12, 32'h0);
    tick(); #1;
    rd_b("freeze_after_te0", 5'd9, 32'h0);
    wr_b(5'd9, 32'h1234);
    tick();
    repeat (8) tick();
    #1;
    rd_b("freeze_count", 5'd9, 32'h1234);
    rd_b("freeze_status", 5'd12, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
